pkt_fifo: RTL and testbench



---
 rtl/pkt_fifo.sv | 93 +++++++++
 tb/tb_pkt_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-granular byte FIFO. Whole packets are written in one
// cycle; the head packet is drained one byte per pop. Packets that arrive
// while full are dropped and flagged in a sticky overflow bit.
module pkt_fifo #(
  parameter int PKTFIFO_DEPTH = 10,
  parameter int PKT_BYTES     = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_cg,
  input  logic [8*PKT_BYTES-1:0]             i_pkt_data,
  input  logic                               i_pkt_valid,
  output logic [7:0]                         o_pktfifo_data,
  output logic                               o_pktfifo_empty,
  input  logic                               i_pktfifo_pop,
  input  logic                               i_pktfifo_flush,
  output logic [$clog2(PKTFIFO_DEPTH+1)-1:0] o_nPkts,
  output logic                               o_overflow
);

  localparam int CW = $clog2(PKTFIFO_DEPTH+1);
  localparam int PW = $clog2(PKTFIFO_DEPTH);
  localparam int BW = $clog2(PKT_BYTES);

  localparam logic [CW-1:0] CNT_FULL = CW'(PKTFIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(PKTFIFO_DEPTH-1);
  localparam logic [BW-1:0] IDX_LAST = BW'(PKT_BYTES-1);

  logic [PKT_BYTES-1:0][7:0] mem [PKTFIFO_DEPTH];
  logic [PKT_BYTES-1:0][7:0] head;

  logic [PW-1:0] wptr, rptr;
  logic [BW-1:0] byte_idx;
  logic [CW-1:0] count;

  logic empty, live, pop_eff, final_pop, push_ok, drop;

  // Qualified events; flush and a low clock-gate suppress everything else.
  always_comb begin
    empty     = (count == '0);
    live      = i_cg && !i_pktfifo_flush;
    pop_eff   = live && i_pktfifo_pop && !empty;
    final_pop = pop_eff && (byte_idx == IDX_LAST);
    push_ok   = live && i_pkt_valid && ((count < CNT_FULL) || final_pop);
    drop      = live && i_pkt_valid && !push_ok;
  end

  // Zero-latency head byte: what is shown is what a pop this cycle consumes.
  always_comb begin
    head           = mem[rptr];
    o_pktfifo_data = empty ? 8'h00 : head[byte_idx];
  end

  assign o_pktfifo_empty = empty;
  assign o_nPkts         = count;

  // Packet storage, written whole; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= i_pkt_data;
  end

  // Pointers, byte index, occupancy and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      byte_idx   <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else if (i_cg && i_pktfifo_flush) begin
      wptr       <= '0;
      rptr       <= '0;
      byte_idx   <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop_eff)
        byte_idx <= final_pop ? '0 : byte_idx + 1'b1;
      if (final_pop)
        rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      if (push_ok)
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      // A push that lands in the same cycle as a packet retiring leaves count alone.
      if (push_ok && !final_pop)
        count <= count + 1'b1;
      else if (!push_ok && final_pop)
        count <= count - 1'b1;
      if (drop)
        o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: directed and random stimulus against a byte-queue reference
// model; popped bytes go to a scoreboard checked by a separate monitor.
module tb_pkt_fifo;
  localparam int PB = 4;
  localparam int D  = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cg = 1'b0;
  logic [8*PB-1:0] i_pkt_data = '0;
  logic          i_pkt_valid = 1'b0;
  logic [7:0]    o_pktfifo_data;
  logic          o_pktfifo_empty;
  logic          i_pktfifo_pop = 1'b0;
  logic          i_pktfifo_flush = 1'b0;
  logic [$clog2(D+1)-1:0] o_nPkts;
  logic          o_overflow;

  pkt_fifo #(.PKTFIFO_DEPTH(D), .PKT_BYTES(PB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg),
    .i_pkt_data(i_pkt_data), .i_pkt_valid(i_pkt_valid),
    .o_pktfifo_data(o_pktfifo_data), .o_pktfifo_empty(o_pktfifo_empty),
    .i_pktfifo_pop(i_pktfifo_pop), .i_pktfifo_flush(i_pktfifo_flush),
    .o_nPkts(o_nPkts), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Reference: all stored bytes in drain order, plus sticky flag.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  function automatic int npk();
    return (mq.size() + PB - 1) / PB;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: each effective pop consumes the next scoreboard byte.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_pktfifo_empty)
        chk("empty_data_zero", {56'd0, o_pktfifo_data}, 64'd0);
      else if (i_cg && i_pktfifo_pop && !i_pktfifo_flush) begin
        if (exp_q.size() == 0)
          chk("unexpected_pop_byte", {56'd0, o_pktfifo_data}, 64'hDEAD);
        else
          chk("pop_byte", {56'd0, o_pktfifo_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic status();
    chk("empty", {63'd0, o_pktfifo_empty}, {63'd0, mq.size() == 0});
    chk("nPkts", 64'(o_nPkts), 64'(npk()));
    chk("overflow", {63'd0, o_overflow}, {63'd0, m_ovf});
    chk("head_data", {56'd0, o_pktfifo_data}, (mq.size() != 0) ? {56'd0, mq[0]} : 64'd0);
  endtask

  // One clock: drive inputs, update model, step, check registered status.
  task automatic step(input logic cg, input logic vld, input logic pop,
                      input logic fl, input logic [8*PB-1:0] d);
    int  n;
    bit  fp;
    i_cg = cg; i_pkt_valid = vld; i_pktfifo_pop = pop;
    i_pktfifo_flush = fl; i_pkt_data = d;
    if (cg) begin
      if (fl) begin
        mq.delete(); m_ovf = 1'b0;
      end else begin
        n  = npk();
        fp = pop && (mq.size() % PB == 1);
        if (pop && mq.size() > 0) exp_q.push_back(mq.pop_front());
        if (vld) begin
          if (n < D || fp) for (int k = 0; k < PB; k++) mq.push_back(d[8*k +: 8]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge i_clk); #1;
    status();
    i_cg = 1'b1; i_pkt_valid = 1'b0; i_pktfifo_pop = 1'b0; i_pktfifo_flush = 1'b0;
  endtask

  task automatic push(input logic [8*PB-1:0] d); step(1, 1, 0, 0, d); endtask
  task automatic pop(input int n); for (int i = 0; i < n; i++) step(1, 0, 1, 0, '0); endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    status();
    @(negedge i_clk) i_rst_n = 1'b1; i_cg = 1'b1;
    @(posedge i_clk); #1;

    // Single packet, byte order.
    push(32'h44332211);
    pop(4);

    // Overflow: D dropped, A,B,C drain in order.
    push(32'hA3A2A1A0); push(32'hB3B2B1B0); push(32'hC3C2C1C0); push(32'hD3D2D1D0);
    pop(12);
    step(1, 0, 0, 1, '0);

    // Push accepted while full because the head retires the same cycle.
    push(32'hA3A2A1A0); push(32'hB3B2B1B0); push(32'hC3C2C1C0);
    pop(3);
    step(1, 1, 1, 0, 32'hE3E2E1E0);
    pop(12);

    // Pointer wrap with full drains.
    for (int i = 0; i < 7; i++) begin
      push($urandom);
      pop(4);
    end

    // Flush mid-packet alongside push and pop.
    push(32'h13121110); push(32'h23222120);
    pop(2);
    step(1, 1, 1, 1, 32'h99999999);
    push(32'h33323130);
    pop(4);

    // Clock gate low: nothing changes.
    push(32'h43424140); pop(1);
    step(0, 1, 1, 0, 32'h55555555);
    step(0, 0, 0, 1, '0);
    step(0, 1, 1, 1, 32'h66666666);
    pop(3);

    // Asynchronous reset mid-packet.
    push(32'h53525150); pop(2);
    #2 i_rst_n = 1'b0;
    #1;
    mq.delete(); exp_q.delete(); m_ovf = 1'b0;
    chk("rst_empty", {63'd0, o_pktfifo_empty}, 64'd1);
    chk("rst_data", {56'd0, o_pktfifo_data}, 64'd0);
    chk("rst_nPkts", 64'(o_nPkts), 64'd0);
    chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    push(32'h63626160);
    pop(4);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, $urandom);
    while (mq.size() > 0) pop(1);
    step(1, 0, 0, 0, '0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
